// File: rtl/capture_ctrl_if.sv
// Capture-control bus: start/stop requests, camera sync, datapath write strobe,
// and the gated frame-buffer write plus status returned by the controller.
interface capture_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int SKIP_W = 4
) ();
    logic              start;
    logic              stop;
    logic              continuous;
    logic [SKIP_W-1:0] skip;
    logic              vsync;
    logic              href;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic              mem_we;
    logic              busy;
    logic              frame_done;
    logic [2:0]        err;
    logic [7:0]        line_cnt;
    logic [7:0]        frame_cnt;

    modport master (
        output start, stop, continuous, skip, vsync, href, cap_we, cap_addr,
        input  mem_we, busy, frame_done, err, line_cnt, frame_cnt
    );

    modport slave (
        input  start, stop, continuous, skip, vsync, href, cap_we, cap_addr,
        output mem_we, busy, frame_done, err, line_cnt, frame_cnt
    );
endinterface

// File: rtl/capture_ctrl.sv
// Camera capture sequencer: arms on a frame boundary, skips settling frames,
// gates frame-buffer writes and reports per-frame pixel/address status.
module capture_ctrl #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int ADDR_W  = 17,
    parameter int SKIP_W  = 4
) (
    input  logic          pclk,
    input  logic          rst,
    capture_ctrl_if.slave bus
);
    localparam int TOTAL = H_PIX * V_LINES;
    localparam int PIX_W = $clog2(TOTAL + 1);
    localparam logic [PIX_W-1:0] TOTAL_C = PIX_W'(TOTAL);

    typedef enum logic [1:0] {IDLE, SYNC, CAPT} state_t;

    state_t            state_q, state_d;
    logic              vs_q, hr_q;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [7:0]        line_cnt_q, line_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [2:0]        err_q, err_d;
    logic              long_q, long_d;
    logic              mis_q, mis_d;
    logic              stop_pend_q, stop_pend_d;
    logic              done_q, done_d;

    logic vs_fall, vs_rise, hr_fall, in_range;

    assign vs_fall  = vs_q & ~bus.vsync;
    assign vs_rise  = ~vs_q & bus.vsync;
    assign hr_fall  = hr_q & ~bus.href;
    assign in_range = pix_cnt_q < TOTAL_C;

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        long_d      = long_q;
        mis_d       = mis_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d     = SYNC;
                    skip_cnt_d  = bus.skip;
                    err_d       = '0;
                    frame_cnt_d = '0;
                end
            end
            SYNC: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    if (skip_cnt_q != '0) begin
                        skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                    end else begin
                        state_d    = CAPT;
                        pix_cnt_d  = '0;
                        line_cnt_d = '0;
                        long_d     = 1'b0;
                        mis_d      = 1'b0;
                    end
                end
            end
            CAPT: begin
                if (bus.cap_we) begin
                    if (in_range) pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    else          long_d    = 1'b1;
                    if (bus.cap_addr != ADDR_W'(pix_cnt_q)) mis_d = 1'b1;
                end
                if (hr_fall && line_cnt_q != 8'hFF) line_cnt_d = line_cnt_q + 8'd1;
                if (bus.stop) stop_pend_d = 1'b1;
                // Frame end uses the flags accumulated up to the previous cycle.
                if (vs_rise) begin
                    err_d  = {mis_q, long_q, in_range};
                    done_d = 1'b1;
                    if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
                    if (bus.continuous && !stop_pend_q && !bus.stop) begin
                        state_d    = SYNC;
                        skip_cnt_d = bus.skip;
                    end else begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vs_q        <= 1'b0;
            hr_q        <= 1'b0;
            skip_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            err_q       <= '0;
            long_q      <= 1'b0;
            mis_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= bus.vsync;
            hr_q        <= bus.href;
            skip_cnt_q  <= skip_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            long_q      <= long_d;
            mis_q       <= mis_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
        end
    end

    // Zero-latency gate keeps the write enable aligned with the datapath address/data.
    assign bus.mem_we     = bus.cap_we & (state_q == CAPT) & in_range;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done_q;
    assign bus.err        = err_q;
    assign bus.line_cnt   = line_cnt_q;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule
